sc_packet_fifo: RTL and testbench

Single-clock Avalon-ST packet FIFO with parametrised data, empty and error widths, parametrised depth, and selectable cut-through or store-and-forward mode. In store-and-forward mode it optionally drops errored packets and always drops oversize packets. It sits between the MAC-side packet sources and the DMA packet sinks wherever both run on one clock, and provides fill-level and almost-full status for upstream flow control.

---
 rtl/sc_packet_fifo.sv | 192 +++++++++++++++++++
 tb/tb_sc_packet_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_packet_fifo.sv
// Single-clock Avalon-ST packet FIFO: cut-through or store-and-forward, with
// errored/oversize packet dropping, fill-level and almost-full status.
module sc_packet_fifo #(
   parameter int unsigned DATA_WIDTH            = 32,
   parameter int unsigned EMPTY_WIDTH           = 2,
   parameter int unsigned ERROR_WIDTH           = 1,
   parameter int unsigned DEPTH                 = 64,
   parameter bit          STORE_AND_FORWARD     = 1'b0,
   parameter bit          DROP_ON_ERROR         = 1'b0,
   parameter int unsigned ALMOST_FULL_THRESHOLD = DEPTH - 4
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset_n,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_startofpacket,
   input  logic                       in_endofpacket,
   input  logic [EMPTY_WIDTH-1:0]     in_empty,
   input  logic [ERROR_WIDTH-1:0]     in_error,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_startofpacket,
   output logic                       out_endofpacket,
   output logic [EMPTY_WIDTH-1:0]     out_empty,
   output logic [ERROR_WIDTH-1:0]     out_error,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       almost_full,
   output logic [15:0]                drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_IN_PKT  = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [EMPTY_WIDTH-1:0] empty;
      logic [ERROR_WIDTH-1:0] error;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        wr_entry;
   entry_t        rd_entry;

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] wr_ptr, wr_ptr_nxt;
   logic [PW-1:0] rd_ptr, rd_ptr_nxt;
   logic [PW-1:0] commit_ptr, commit_ptr_nxt;
   logic [PW-1:0] pkt_start, pkt_start_nxt;
   logic [PW-1:0] fill_nxt;
   logic [15:0]   drop_count_nxt;
   logic          ready_en;
   logic          full;
   logic          wr_beat;
   logic          rd_beat;
   logic          store;
   logic          drop;
   logic          err_drop;

   // Status derived from registered pointers; ready_en holds in_ready low through reset.
   assign full      = (wr_ptr - rd_ptr) == PW'(DEPTH);
   assign in_ready  = ready_en && (!full || (state == ST_DISCARD));
   assign out_valid = (rd_ptr != commit_ptr);
   assign wr_beat   = in_valid && in_ready;
   assign rd_beat   = out_valid && out_ready;
   assign err_drop  = DROP_ON_ERROR && STORE_AND_FORWARD && (|in_error);

   assign wr_entry = '{data:  in_data,
                       sop:   in_startofpacket,
                       eop:   in_endofpacket,
                       empty: in_empty,
                       error: in_error};

   assign rd_entry = mem[rd_ptr[AW-1:0]];

   // Source fields read zero whenever nothing is presented, including reset.
   assign out_data          = out_valid ? rd_entry.data  : '0;
   assign out_startofpacket = out_valid && rd_entry.sop;
   assign out_endofpacket   = out_valid && rd_entry.eop;
   assign out_empty         = out_valid ? rd_entry.empty : '0;
   assign out_error         = out_valid ? rd_entry.error : '0;

   // Write-side FSM and pointer update.
   always_comb begin
      state_nxt      = state;
      wr_ptr_nxt     = wr_ptr;
      commit_ptr_nxt = commit_ptr;
      pkt_start_nxt  = pkt_start;
      rd_ptr_nxt     = rd_ptr + PW'(rd_beat);
      store          = 1'b0;
      drop           = 1'b0;

      if (!STORE_AND_FORWARD) begin
         if (wr_beat) begin
            store      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
         end
         commit_ptr_nxt = wr_ptr_nxt;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_beat) begin
                  pkt_start_nxt = wr_ptr;
                  if (!in_endofpacket) begin
                     store      = 1'b1;
                     wr_ptr_nxt = wr_ptr + PW'(1);
                     state_nxt  = ST_IN_PKT;
                  end else if (err_drop) begin
                     drop = 1'b1;
                  end else begin
                     store          = 1'b1;
                     wr_ptr_nxt     = wr_ptr + PW'(1);
                     commit_ptr_nxt = wr_ptr + PW'(1);
                  end
               end
            end
            ST_IN_PKT: begin
               if (wr_beat) begin
                  if (!in_endofpacket) begin
                     store      = 1'b1;
                     wr_ptr_nxt = wr_ptr + PW'(1);
                  end else if (err_drop) begin
                     drop       = 1'b1;
                     wr_ptr_nxt = pkt_start;
                     state_nxt  = ST_IDLE;
                  end else begin
                     store          = 1'b1;
                     wr_ptr_nxt     = wr_ptr + PW'(1);
                     commit_ptr_nxt = wr_ptr + PW'(1);
                     state_nxt      = ST_IDLE;
                  end
               end else if (in_valid && full) begin
                  // Packet cannot fit: rewind and swallow the rest of it.
                  drop       = 1'b1;
                  wr_ptr_nxt = pkt_start;
                  state_nxt  = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (wr_beat && in_endofpacket) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end

      fill_nxt       = wr_ptr_nxt - rd_ptr_nxt;
      drop_count_nxt = (drop && (drop_count != 16'hFFFF)) ? drop_count + 16'd1 : drop_count;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state       <= ST_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         commit_ptr  <= '0;
         pkt_start   <= '0;
         ready_en    <= 1'b0;
         fill_level  <= '0;
         almost_full <= 1'b0;
         drop_count  <= '0;
      end else begin
         state       <= state_nxt;
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         commit_ptr  <= commit_ptr_nxt;
         pkt_start   <= pkt_start_nxt;
         ready_en    <= 1'b1;
         fill_level  <= fill_nxt;
         almost_full <= (32'(fill_nxt) >= ALMOST_FULL_THRESHOLD);
         drop_count  <= drop_count_nxt;
      end
   end

   // Storage array carries no reset; unread contents are masked at the output.
   always_ff @(posedge clk_clk) begin
      if (store) begin
         mem[wr_ptr[AW-1:0]] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_sc_packet_fifo.sv
// Bench for sc_packet_fifo: a cut-through and a store-and-forward/drop-on-error
// instance checked every cycle against a packet-level queue model.
module tb_sc_packet_fifo;

   localparam int DEPTH = 8;
   localparam int MQ    = 1024;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic [0:0]  error;
   } beat_t;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        e_ready;
      logic        e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_fill;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;

   logic [31:0] snk_data  [2];
   logic        snk_valid [2];
   logic        snk_ready [2];
   logic        snk_sop   [2];
   logic        snk_eop   [2];
   logic [1:0]  snk_empty [2];
   logic [0:0]  snk_error [2];
   logic [31:0] src_data  [2];
   logic        src_valid [2];
   logic        src_ready [2];
   logic        src_sop   [2];
   logic        src_eop   [2];
   logic [1:0]  src_empty [2];
   logic [0:0]  src_error [2];
   logic [3:0]  fill      [2];
   logic        afull     [2];
   logic [15:0] drops     [2];

   // Model: absolute beat indices; committed = [rd, cm), pending packet = [cm, wr).
   beat_t mq [2][MQ];
   int    m_rd [2];
   int    m_cm [2];
   int    m_wr [2];
   int    m_drops [2];
   int    reads [2];
   int    g_pos [2];
   bit    m_disc [2];
   bit    acc [2];

   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   sc_packet_fifo #(
      .DATA_WIDTH(32), .EMPTY_WIDTH(2), .ERROR_WIDTH(1), .DEPTH(DEPTH),
      .STORE_AND_FORWARD(1'b0), .DROP_ON_ERROR(1'b0), .ALMOST_FULL_THRESHOLD(4)
   ) u_ct (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .in_data(snk_data[0]), .in_valid(snk_valid[0]), .in_ready(snk_ready[0]),
      .in_startofpacket(snk_sop[0]), .in_endofpacket(snk_eop[0]),
      .in_empty(snk_empty[0]), .in_error(snk_error[0]),
      .out_data(src_data[0]), .out_valid(src_valid[0]), .out_ready(src_ready[0]),
      .out_startofpacket(src_sop[0]), .out_endofpacket(src_eop[0]),
      .out_empty(src_empty[0]), .out_error(src_error[0]),
      .fill_level(fill[0]), .almost_full(afull[0]), .drop_count(drops[0])
   );

   sc_packet_fifo #(
      .DATA_WIDTH(32), .EMPTY_WIDTH(2), .ERROR_WIDTH(1), .DEPTH(DEPTH),
      .STORE_AND_FORWARD(1'b1), .DROP_ON_ERROR(1'b1), .ALMOST_FULL_THRESHOLD(4)
   ) u_sf (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .in_data(snk_data[1]), .in_valid(snk_valid[1]), .in_ready(snk_ready[1]),
      .in_startofpacket(snk_sop[1]), .in_endofpacket(snk_eop[1]),
      .in_empty(snk_empty[1]), .in_error(snk_error[1]),
      .out_data(src_data[1]), .out_valid(src_valid[1]), .out_ready(src_ready[1]),
      .out_startofpacket(src_sop[1]), .out_endofpacket(src_eop[1]),
      .out_empty(src_empty[1]), .out_error(src_error[1]),
      .fill_level(fill[1]), .almost_full(afull[1]), .drop_count(drops[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_rd[i] = 0; m_cm[i] = 0; m_wr[i] = 0; m_drops[i] = 0;
         reads[i] = 0; g_pos[i] = 0; m_disc[i] = 1'b0; acc[i] = 1'b0;
      end
   endtask

   task automatic drive_idle(input int i);
      snk_valid[i] = 1'b0; snk_data[i] = '0; snk_sop[i] = 1'b0;
      snk_eop[i] = 1'b0; snk_empty[i] = '0; snk_error[i] = '0;
   endtask

   task automatic set_beat(input int i, input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] em, input logic [0:0] er);
      snk_valid[i] = 1'b1; snk_data[i] = d; snk_sop[i] = s;
      snk_eop[i] = e; snk_empty[i] = em; snk_error[i] = er;
   endtask

   // Apply one clock: accepted beats and drops follow the packet rules.
   task automatic model_step(input int i, input bit er, input bit ev);
      beat_t nb;
      int    fl;
      bit    w;
      fl = m_wr[i] - m_rd[i];
      nb.data = snk_data[i]; nb.sop = snk_sop[i]; nb.eop = snk_eop[i];
      nb.empty = snk_empty[i]; nb.error = snk_error[i];
      w = snk_valid[i] && er;
      acc[i] = w;
      if (ev && src_ready[i]) begin
         m_rd[i]++;
         reads[i]++;
      end
      if (i == 0) begin
         if (w) begin
            mq[i][m_wr[i] % MQ] = nb;
            m_wr[i]++;
         end
         m_cm[i] = m_wr[i];
      end else if (m_disc[i]) begin
         if (w && nb.eop) m_disc[i] = 1'b0;
      end else if (w) begin
         if (nb.eop && nb.error != 0) begin
            m_wr[i] = m_cm[i];
            m_drops[i]++;
         end else begin
            mq[i][m_wr[i] % MQ] = nb;
            m_wr[i]++;
            if (nb.eop) m_cm[i] = m_wr[i];
         end
      end else if (snk_valid[i] && (m_wr[i] > m_cm[i]) && (fl == DEPTH)) begin
         m_wr[i] = m_cm[i];
         m_disc[i] = 1'b1;
         m_drops[i]++;
      end
   endtask

   // Called at a negedge: compare both instances, step the model across one posedge.
   task automatic cycle();
      bit er [2];
      bit ev [2];
      for (int i = 0; i < 2; i++) begin
         int    fl;
         beat_t b;
         fl = m_wr[i] - m_rd[i];
         er[i] = (fl < DEPTH) || m_disc[i];
         ev[i] = m_cm[i] > m_rd[i];
         b = mq[i][m_rd[i] % MQ];
         chk($sformatf("u%0d in_ready", i), 64'(snk_ready[i]), 64'(er[i]));
         chk($sformatf("u%0d out_valid", i), 64'(src_valid[i]), 64'(ev[i]));
         chk($sformatf("u%0d fill_level", i), 64'(fill[i]), 64'(fl));
         chk($sformatf("u%0d almost_full", i), 64'(afull[i]), 64'(fl >= 4));
         chk($sformatf("u%0d drop_count", i), 64'(drops[i]), 64'(m_drops[i]));
         if (ev[i]) begin
            chk($sformatf("u%0d out_data", i), 64'(src_data[i]), 64'(b.data));
            chk($sformatf("u%0d out_sop", i), 64'(src_sop[i]), 64'(b.sop));
            chk($sformatf("u%0d out_eop", i), 64'(src_eop[i]), 64'(b.eop));
            chk($sformatf("u%0d out_empty", i), 64'(src_empty[i]), 64'(b.empty));
            chk($sformatf("u%0d out_error", i), 64'(src_error[i]), 64'(b.error));
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, er[i], ev[i]);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s u%0d in_ready", tag, i), 64'(snk_ready[i]), 64'd0);
         chk($sformatf("%s u%0d out_valid", tag, i), 64'(src_valid[i]), 64'd0);
         chk($sformatf("%s u%0d out_data", tag, i), 64'(src_data[i]), 64'd0);
         chk($sformatf("%s u%0d fill_level", tag, i), 64'(fill[i]), 64'd0);
         chk($sformatf("%s u%0d almost_full", tag, i), 64'(afull[i]), 64'd0);
         chk($sformatf("%s u%0d drop_count", tag, i), 64'(drops[i]), 64'd0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) drive_idle(i);
      model_reset();
      @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("release u%0d in_ready before edge", i), 64'(snk_ready[i]), 64'd0);
      @(negedge clk);
   endtask

   task automatic send_pkt(input int i, input int n, input logic [31:0] base, input logic [0:0] err);
      for (int k = 0; k < n; k++) begin
         int t;
         t = 0;
         set_beat(i, base + 32'(k), k == 0, k == n - 1, 2'(k), (k == n - 1) ? err : 1'b0);
         do begin
            cycle();
            t++;
         end while (!acc[i] && t < 40);
         chk($sformatf("u%0d beat %0d accepted", i, k), 64'(acc[i]), 64'd1);
      end
      drive_idle(i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [7];
      int   wrote;
      logic e;

      for (int i = 0; i < 2; i++) begin
         drive_idle(i);
         src_ready[i] = 1'b0;
      end

      // Cut-through, 5 back-to-back beats with the sink draining.
      do_reset();
      tbl[0] = '{1'b1, 32'hA0, 1'b1, 1'b0, 32'h00, 4'd0};
      tbl[1] = '{1'b1, 32'hA1, 1'b1, 1'b1, 32'hA0, 4'd1};
      tbl[2] = '{1'b1, 32'hA2, 1'b1, 1'b1, 32'hA1, 4'd1};
      tbl[3] = '{1'b1, 32'hA3, 1'b1, 1'b1, 32'hA2, 4'd1};
      tbl[4] = '{1'b1, 32'hA4, 1'b1, 1'b1, 32'hA3, 4'd1};
      tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hA4, 4'd1};
      tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'd0};
      src_ready[0] = 1'b1;
      src_ready[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("tbl%0d in_ready", k), 64'(snk_ready[0]), 64'(tbl[k].e_ready));
         chk($sformatf("tbl%0d out_valid", k), 64'(src_valid[0]), 64'(tbl[k].e_valid));
         if (tbl[k].e_valid)
            chk($sformatf("tbl%0d out_data", k), 64'(src_data[0]), 64'(tbl[k].e_data));
         chk($sformatf("tbl%0d fill_level", k), 64'(fill[0]), 64'(tbl[k].e_fill));
         if (tbl[k].v) set_beat(0, tbl[k].d, k == 0, k == 4, 2'd0, 1'b0);
         else          drive_idle(0);
         cycle();
      end

      // Store-and-forward: 4-beat packet held until EOP is written.
      do_reset();
      src_ready[1] = 1'b1;
      send_pkt(1, 4, 32'hB0, 1'b0);
      repeat (6) cycle();
      chk("sf 4-beat beats read", 64'(reads[1]), 64'd4);

      // Errored packet B dropped between A and C.
      do_reset();
      src_ready[1] = 1'b1;
      send_pkt(1, 3, 32'hC0, 1'b0);
      send_pkt(1, 3, 32'hD0, 1'b1);
      send_pkt(1, 2, 32'hE0, 1'b0);
      repeat (6) cycle();
      chk("err-drop drop_count", 64'(drops[1]), 64'd1);
      chk("err-drop beats read", 64'(reads[1]), 64'd5);
      chk("err-drop fill_level", 64'(fill[1]), 64'd0);

      // Oversize 12-beat packet with the source stalled.
      do_reset();
      src_ready[1] = 1'b0;
      send_pkt(1, 12, 32'h100, 1'b0);
      cycle();
      chk("oversize fill_level", 64'(fill[1]), 64'd0);
      chk("oversize drop_count", 64'(drops[1]), 64'd1);
      chk("oversize out_valid", 64'(src_valid[1]), 64'd0);
      src_ready[1] = 1'b1;
      send_pkt(1, 2, 32'h200, 1'b0);
      repeat (4) cycle();
      chk("post-oversize beats read", 64'(reads[1]), 64'd2);

      // Cut-through fill to full, then continuous traffic across pointer wrap.
      do_reset();
      src_ready[0] = 1'b0;
      wrote = 0;
      for (int c = 0; c < 50; c++) begin
         if (c == 10) begin
            chk("full in_ready", 64'(snk_ready[0]), 64'd0);
            chk("full almost_full", 64'(afull[0]), 64'd1);
            chk("full fill_level", 64'(fill[0]), 64'd8);
            src_ready[0] = 1'b1;
         end
         set_beat(0, 32'h300 + 32'(wrote), 1'b1, 1'b1, 2'd0, 1'b0);
         cycle();
         if (acc[0]) wrote++;
      end
      drive_idle(0);
      repeat (12) cycle();
      chk("wrap beats read == written", 64'(reads[0]), 64'(wrote));

      // Asynchronous reset in the middle of a packet.
      do_reset();
      src_ready[0] = 1'b0;
      src_ready[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) set_beat(i, 32'h400 + 32'(k), k == 0, 1'b0, 2'd0, 1'b0);
         cycle();
      end
      for (int i = 0; i < 2; i++) drive_idle(i);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      src_ready[1] = 1'b1;
      send_pkt(1, 4, 32'h500, 1'b0);
      repeat (6) cycle();
      chk("post-reset beats read", 64'(reads[1]), 64'd4);
      chk("post-reset drop_count", 64'(drops[1]), 64'd0);

      // Randomized traffic on both instances.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            src_ready[i] = ($urandom_range(0, 9) < 7);
            if (!(snk_valid[i] && !acc[i])) begin
               if ($urandom_range(0, 3) != 0) begin
                  e = ($urandom_range(0, 5) == 0);
                  set_beat(i, $urandom, g_pos[i] == 0, e, 2'($urandom_range(0, 3)),
                           1'(e && ($urandom_range(0, 3) == 0)));
               end else begin
                  drive_idle(i);
               end
            end
         end
         cycle();
         for (int i = 0; i < 2; i++)
            if (acc[i]) g_pos[i] = snk_eop[i] ? 0 : g_pos[i] + 1;
      end
      for (int i = 0; i < 2; i++) begin
         drive_idle(i);
         src_ready[i] = 1'b1;
      end
      repeat (30) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
